rf_write_arb: RTL and testbench
===============================

RF_WRITE_ARB -- requirements
Module: rf_write_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles port 1 may wait while valid before forced grant; legal 1..7.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 p0_valid  input  1  port 0 (pipeline write-back) write request.
REQ-005 p0_reg  input  5  port 0 destination register.
REQ-006 p0_data  input  32  port 0 write data.
REQ-007 p0_ready  output  1  port 0 request accepted this cycle (combinational).
REQ-008 p1_valid  input  1  port 1 (multicycle mul/div unit) write request.
REQ-009 p1_reg  input  5  port 1 destination register.
REQ-010 p1_data  input  32  port 1 write data.
REQ-011 p1_ready  output  1  port 1 request accepted this cycle (combinational).
REQ-012 RegWrite  output  1  registered write enable to register file.
REQ-013 WriteRegister  output  5  registered write address to register file.
REQ-014 WriteData  output  32  registered write data to register file.

Function
REQ-015 Transfer on a port occurs at a posedge where valid and ready are both high; requester holds reg and data stable while valid and not ready.
REQ-016 At most one transfer per cycle; p0_ready and p1_ready never both high.
REQ-017 FSM states NORMAL and FORCE1; reset state NORMAL.
REQ-018 NORMAL: p0_ready = p0_valid-independent 1; p1_ready = !p0_valid (port 0 fixed priority).
REQ-019 FORCE1: p1_ready = 1, p0_ready = 0.
REQ-020 starve_cnt (3 bits): increments when p1_valid and no port-1 transfer; clears on port-1 transfer or p1_valid low; saturates at 7.
REQ-021 NORMAL -> FORCE1 when starve_cnt reaches STARVE_LIMIT with p1_valid high; FORCE1 -> NORMAL after exactly one cycle (port-1 transfer occurs, starve_cnt clears).
REQ-022 Latency: transfer at edge N drives RegWrite=1, WriteRegister, WriteData at edge N; values visible during cycle N+1; register file commits at edge N+1.
REQ-023 No transfer at an edge -> RegWrite=0 after that edge; WriteRegister/WriteData hold previous values.
REQ-024 Transfer with reg = 0 is accepted (ready behaves normally) but RegWrite=0 after that edge.
REQ-025 Both ports valid to same register: writes occur in grant order, one per cycle; the later grant's data is final.
REQ-026 p1_valid dropped while in FORCE1 (protocol violation): no transfer, return to NORMAL, starve_cnt cleared.

Reset
REQ-027 rst high at posedge: RegWrite=0, WriteRegister=0, WriteData=0, state NORMAL, starve_cnt=0, regardless of in-flight requests.
REQ-028 While rst high, p0_ready=0 and p1_ready=0; no transfer is recorded on a reset edge.
REQ-029 Requests held across reset deassertion are arbitrated afresh from NORMAL on the first post-reset cycle.

Configuration
REQ-030 Macro RF_WRITE_ARB_STATS_EN defined: adds output p0_stall_cnt [15:0], counting cycles with p0_valid=1 and p0_ready=0, saturating at 16'hFFFF, cleared by rst.
REQ-031 Macro undefined: no p0_stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-032 Reset: rst=1 one edge with both ports valid -> RegWrite=0, WriteRegister=0, WriteData=0, both ready=0.
REQ-033 p0 only: p0_valid=1, p0_reg=5, p0_data=32'hDEADBEEF -> p0_ready=1; next cycle RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF.
REQ-034 Starvation, STARVE_LIMIT=4: p0 and p1 valid continuously -> four p0 transfers, fifth cycle p1 granted (p1_ready=1, p0_ready=0), then p0 resumes; pattern repeats every 5 cycles.
REQ-035 R0 discard: p1_valid=1, p1_reg=0, p0 idle -> p1_ready=1, next cycle RegWrite=0.
REQ-036 Same register: p0 and p1 both target reg 9 (p0 data 1, p1 data 2) -> writes reg 9 with 1 then 2 on consecutive cycles.
REQ-037 With RF_WRITE_ARB_STATS_EN: p1 forced once during 10 cycles of continuous p0_valid -> p0_stall_cnt=1 (STARVE_LIMIT=4, p1 valid throughout first 5 cycles only).

Source files
------------

// File: rtl/rf_write_arb.sv
// Two-port register-file write arbiter: port 0 has fixed priority, port 1 gets a forced grant after STARVE_LIMIT stalled cycles.
// Optional RF_WRITE_ARB_STATS_EN adds a saturating port-0 stall counter output.
module rf_write_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [4:0]  p0_reg,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_reg,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [15:0] p0_stall_cnt
`endif
);

  typedef enum logic {NORMAL, FORCE1} state_t;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] data;
  } wr_req_t;

  state_t     state;
  logic [2:0] starve_cnt;
  logic [2:0] cnt_nxt;
  logic       p0_xfer, p1_xfer;
  wr_req_t    req0, req1;

  assign req0 = '{rg: p0_reg, data: p0_data};
  assign req1 = '{rg: p1_reg, data: p1_data};

  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          p0_ready = 1'b1;
          p1_ready = !p0_valid;
        end
        FORCE1: p1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign p0_xfer = p0_valid && p0_ready;
  assign p1_xfer = p1_valid && p1_ready;

  always_comb begin
    cnt_nxt = 3'd0;
    if (p1_valid && !p1_xfer)
      cnt_nxt = (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= NORMAL;
      starve_cnt    <= 3'd0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      starve_cnt <= cnt_nxt;
      case (state)
        NORMAL:  if (p1_valid && cnt_nxt >= 3'(STARVE_LIMIT)) state <= FORCE1;
        FORCE1:  state <= NORMAL;
        default: state <= NORMAL;
      endcase
      // writes to r0 are accepted but never reach the register file
      if (p0_xfer) begin
        RegWrite      <= |req0.rg;
        WriteRegister <= req0.rg;
        WriteData     <= req0.data;
      end else if (p1_xfer) begin
        RegWrite      <= |req1.rg;
        WriteRegister <= req1.rg;
        WriteData     <= req1.data;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

`ifdef RF_WRITE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      p0_stall_cnt <= 16'd0;
    else if (p0_valid && !p0_ready && p0_stall_cnt != 16'hFFFF)
      p0_stall_cnt <= p0_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rf_write_arb.sv
// Directed bench for rf_write_arb (STARVE_LIMIT=4); stall-counter check only with RF_WRITE_ARB_STATS_EN.
module tb_rf_write_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic [4:0]  p0_reg = '0, p1_reg = '0;
  logic [31:0] p0_data = '0, p1_data = '0;
  logic        p0_ready, p1_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0] p0_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rf_write_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_reg(p0_reg), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_reg(p1_reg), .p1_data(p1_data), .p1_ready(p1_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
`ifdef RF_WRITE_ARB_STATS_EN
    , .p0_stall_cnt(p0_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    p0_valid = v0; p0_reg = r0; p0_data = d0;
    p1_valid = v1; p1_reg = r1; p1_data = d1;
    #1;
  endtask

  initial begin
    // reset with both ports requesting
    #1;
    drive(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_p1_ready", p1_ready, 0);
    tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", WriteRegister, 0);
    chk("rst_wdata", WriteData, 0);
    rst = 1'b0;

    // p0 only
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    chk("p0_ready", p0_ready, 1);
    chk("p0_p1_ready", p1_ready, 0);
    tick();
    chk("p0_regwrite", RegWrite, 1);
    chk("p0_wreg", WriteRegister, 5);
    chk("p0_wdata", WriteData, 32'hDEADBEEF);

    // idle: enable drops, address/data hold
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    tick();
    chk("idle_regwrite", RegWrite, 0);
    chk("idle_wreg", WriteRegister, 5);
    chk("idle_wdata", WriteData, 32'hDEADBEEF);

    // r0 discard through port 1
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
    chk("r0_p1_ready", p1_ready, 1);
    tick();
    chk("r0_regwrite", RegWrite, 0);

    // starvation: p1 forced every fifth cycle
    for (int k = 0; k < 10; k++) begin
      drive(1, 5'd1, 32'd100 + k, 1, 5'd2, 32'd200 + k);
      chk($sformatf("starve%0d_p0_ready", k), p0_ready, (k % 5 == 4) ? 0 : 1);
      chk($sformatf("starve%0d_p1_ready", k), p1_ready, (k % 5 == 4) ? 1 : 0);
      tick();
      chk($sformatf("starve%0d_regwrite", k), RegWrite, 1);
      chk($sformatf("starve%0d_wreg", k), WriteRegister, (k % 5 == 4) ? 2 : 1);
      chk($sformatf("starve%0d_wdata", k), WriteData, (k % 5 == 4) ? 200 + k : 100 + k);
    end

    // same destination: p0 first, then p1
    drive(1, 5'd9, 32'd1, 1, 5'd9, 32'd2);
    tick();
    chk("same_wreg0", WriteRegister, 9);
    chk("same_wdata0", WriteData, 1);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'd2);
    chk("same_p1_ready", p1_ready, 1);
    tick();
    chk("same_regwrite1", RegWrite, 1);
    chk("same_wdata1", WriteData, 2);

    // p1 withdraws while forced: no transfer, back to NORMAL
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd6, 32'd300 + k, 1, 5'd7, 32'd400);
      tick();
    end
    chk("pre_force_wdata", WriteData, 303);
    drive(1, 5'd6, 32'd500, 0, 5'd7, 32'd400);
    chk("force_p0_ready", p0_ready, 0);
    chk("force_p1_ready", p1_ready, 1);
    tick();
    chk("drop_regwrite", RegWrite, 0);
    chk("drop_wdata_hold", WriteData, 303);
    drive(1, 5'd6, 32'd501, 1, 5'd7, 32'd400);
    chk("drop_normal_p0", p0_ready, 1);
    chk("drop_normal_p1", p1_ready, 0);
    tick();
    chk("drop_wdata", WriteData, 501);

    // reset mid-traffic, requests held across deassertion
    rst = 1'b1;
    drive(1, 5'd8, 32'd600, 1, 5'd10, 32'd700);
    chk("rst2_p0_ready", p0_ready, 0);
    chk("rst2_p1_ready", p1_ready, 0);
    tick();
    chk("rst2_regwrite", RegWrite, 0);
    chk("rst2_wreg", WriteRegister, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_p0", p0_ready, 1);
    chk("post_rst_p1", p1_ready, 0);
    tick();
    chk("post_rst_wreg", WriteRegister, 8);

`ifdef RF_WRITE_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 5'd3, 32'd800 + k, (k < 5), 5'd4, 32'd900);
      tick();
    end
    chk("stall_cnt", p0_stall_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
